// File: rtl/fetch_pc_unit.sv
// Instruction-fetch stage: drives the word PC to instruction memory and registers the word into IF/ID.
// First word one cycle after start is accepted; the output register holds steady while out_valid && !out_ready.
module fetch_pc_unit #(
   parameter logic [31:0] RESET_PC  = 32'd0,
   parameter int          NUM_INSTR = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   output logic [31:0] program_counter,
   input  logic [31:0] instruction,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_target,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_instruction,
   output logic [31:0] out_pc,
   output logic        halted,
   output logic        fetch_error
);

   localparam logic [31:0] NUM_WORDS = 32'(NUM_INSTR);
   localparam logic [31:0] LAST_PC   = 32'(NUM_INSTR - 1);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      FETCH  = 2'd1,
      HALTED = 2'd2
   } state_t;

   state_t      state, state_nx;
   logic [31:0] pc, pc_nx;
   logic [31:0] out_instruction_nx, out_pc_nx;
   logic        out_valid_nx, fetch_error_nx;

   always_ff @(posedge clk) begin
      if (rst) begin
         state           <= IDLE;
         pc              <= RESET_PC;
         out_valid       <= 1'b0;
         out_instruction <= 32'd0;
         out_pc          <= 32'd0;
         fetch_error     <= 1'b0;
      end else begin
         state           <= state_nx;
         pc              <= pc_nx;
         out_valid       <= out_valid_nx;
         out_instruction <= out_instruction_nx;
         out_pc          <= out_pc_nx;
         fetch_error     <= fetch_error_nx;
      end
   end

   always_comb begin
      state_nx           = state;
      pc_nx              = pc;
      out_valid_nx       = out_valid;
      out_instruction_nx = out_instruction;
      out_pc_nx          = out_pc;
      fetch_error_nx     = fetch_error;

      if (redirect_valid) begin
         // Flush wins over any handshake in the same cycle.
         out_valid_nx = 1'b0;
         pc_nx        = redirect_target;
         if (redirect_target < NUM_WORDS) begin
            state_nx = (state == IDLE) ? IDLE : FETCH;
         end else begin
            state_nx       = HALTED;
            fetch_error_nx = 1'b1;
         end
      end else begin
         case (state)
            IDLE: begin
               if (out_valid && out_ready) out_valid_nx = 1'b0;
               if (start) state_nx = FETCH;
            end
            FETCH: begin
               if (!out_valid || out_ready) begin
                  out_instruction_nx = instruction;
                  out_pc_nx          = pc;
                  out_valid_nx       = 1'b1;
                  pc_nx              = pc + 32'd1;
                  if (pc == LAST_PC) state_nx = HALTED;
               end
            end
            HALTED: begin
               if (out_valid && out_ready) out_valid_nx = 1'b0;
            end
            default: state_nx = IDLE;
         endcase
      end
   end

   assign program_counter = pc;
   assign halted          = (state == HALTED);

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Self-checking bench for fetch_pc_unit: directed scenarios plus a randomized run against a behavioural model.
module tb_fetch_pc_unit;

   localparam int          N  = 8;
   localparam logic [31:0] NW = 32'd8;

   logic        clk = 1'b0;
   logic        rst, start, redirect_valid, out_ready;
   logic [31:0] redirect_target, program_counter, instruction, out_instruction, out_pc;
   logic        out_valid, halted, fetch_error;
   logic [31:0] mem [N];

   int vectors = 0;
   int errors  = 0;

   // Behavioural model: running = fetching words, stopped = halted after image end or bad target.
   logic [31:0] m_pc, m_oi, m_opc;
   logic        m_ov, m_running, m_stopped, m_err;

   always #5 clk = ~clk;

   fetch_pc_unit #(.RESET_PC(32'd0), .NUM_INSTR(N)) dut (
      .clk(clk), .rst(rst), .start(start),
      .program_counter(program_counter), .instruction(instruction),
      .redirect_valid(redirect_valid), .redirect_target(redirect_target),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_instruction(out_instruction), .out_pc(out_pc),
      .halted(halted), .fetch_error(fetch_error)
   );

   function automatic logic [31:0] word_at(input logic [31:0] a);
      if (a < NW) return mem[a[2:0]];
      return 32'hBAD0_0000 ^ a;
   endfunction

   assign instruction = word_at(program_counter);

   task automatic model_step();
      if (rst) begin
         m_pc = 0; m_oi = 0; m_opc = 0; m_ov = 0;
         m_running = 0; m_stopped = 0; m_err = 0;
      end else if (redirect_valid) begin
         m_ov = 0;
         m_pc = redirect_target;
         if (redirect_target < NW) begin
            m_running = m_running | m_stopped;
            m_stopped = 0;
         end else begin
            m_running = 0; m_stopped = 1; m_err = 1;
         end
      end else if (m_running) begin
         if (!m_ov || out_ready) begin
            m_oi = word_at(m_pc);
            m_opc = m_pc;
            m_ov = 1;
            if (m_pc == NW - 1) begin m_running = 0; m_stopped = 1; end
            m_pc = m_pc + 1;
         end
      end else begin
         if (m_ov && out_ready) m_ov = 0;
         if (!m_stopped && start) m_running = 1;
      end
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      #1;
   endtask

   task automatic go();
      rst = 1; tick(); rst = 0; tick();
      start = 1; tick(); start = 0;
   endtask

   task automatic test_reset();
      rst = 1; start = 0; redirect_valid = 0; redirect_target = 0; out_ready = 1;
      tick(); tick();
      vectors++;
      if ({out_valid, halted, fetch_error, out_pc, out_instruction, program_counter} !== {3'b000, 96'd0}) begin
         errors++;
         $display("FAIL reset: ov=%b h=%b err=%b opc=%h oi=%h pc=%h, want all zero",
                  out_valid, halted, fetch_error, out_pc, out_instruction, program_counter);
      end
   endtask

   task automatic test_sequential();
      out_ready = 1;
      go();
      vectors++;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL seq_latency: ov=%b want 0", out_valid); end
      for (int k = 0; k < N; k++) begin
         tick();
         vectors++;
         if (out_valid !== 1'b1 || out_pc !== 32'(k) || out_instruction !== mem[k]) begin
            errors++;
            $display("FAIL seq_word%0d: ov=%b opc=%h oi=%h want 1 %h %h", k, out_valid, out_pc, out_instruction, 32'(k), mem[k]);
         end
      end
      vectors++;
      if (halted !== 1'b1) begin errors++; $display("FAIL seq_halt: halted=%b want 1", halted); end
      tick();
      vectors++;
      if (out_valid !== 1'b0 || halted !== 1'b1) begin
         errors++; $display("FAIL seq_drain: ov=%b h=%b want 0 1", out_valid, halted);
      end
   endtask

   task automatic test_stall();
      out_ready = 1;
      go();
      tick(); tick(); tick();
      out_ready = 0;
      for (int i = 0; i < 3; i++) begin
         tick();
         vectors++;
         if (out_valid !== 1'b1 || out_pc !== 32'd2 || out_instruction !== mem[2] || program_counter !== 32'd3) begin
            errors++;
            $display("FAIL stall_hold%0d: ov=%b opc=%h oi=%h pc=%h want 1 2 %h 3", i, out_valid, out_pc, out_instruction, mem[2], program_counter);
         end
      end
      out_ready = 1;
      tick();
      vectors++;
      if (out_pc !== 32'd3 || out_instruction !== mem[3]) begin
         errors++; $display("FAIL stall_release: opc=%h oi=%h want 3 %h", out_pc, out_instruction, mem[3]);
      end
   endtask

   task automatic test_redirect();
      out_ready = 1;
      go();
      repeat (5) tick();
      vectors++;
      if (out_pc !== 32'd4) begin errors++; $display("FAIL redir_pre: opc=%h want 4", out_pc); end
      redirect_valid = 1; redirect_target = 32'd1;
      tick();
      redirect_valid = 0;
      vectors++;
      if (out_valid !== 1'b0 || program_counter !== 32'd1) begin
         errors++; $display("FAIL redir_flush: ov=%b pc=%h want 0 1", out_valid, program_counter);
      end
      for (int k = 1; k <= 3; k++) begin
         tick();
         vectors++;
         if (out_valid !== 1'b1 || out_pc !== 32'(k) || out_instruction !== mem[k]) begin
            errors++; $display("FAIL redir_word%0d: ov=%b opc=%h want 1 %h", k, out_valid, out_pc, 32'(k));
         end
      end
   endtask

   task automatic test_bad_target();
      redirect_valid = 1; redirect_target = 32'd9;
      tick();
      redirect_valid = 0;
      vectors++;
      if (halted !== 1'b1 || fetch_error !== 1'b1 || out_valid !== 1'b0) begin
         errors++; $display("FAIL bad_target: h=%b err=%b ov=%b want 1 1 0", halted, fetch_error, out_valid);
      end
      repeat (3) tick();
      vectors++;
      if (out_valid !== 1'b0 || halted !== 1'b1) begin
         errors++; $display("FAIL bad_no_capture: ov=%b h=%b want 0 1", out_valid, halted);
      end
      redirect_valid = 1; redirect_target = 32'd0;
      tick();
      redirect_valid = 0;
      tick();
      vectors++;
      if (out_valid !== 1'b1 || out_pc !== 32'd0 || halted !== 1'b0 || fetch_error !== 1'b1) begin
         errors++; $display("FAIL bad_resume: ov=%b opc=%h h=%b err=%b want 1 0 0 1", out_valid, out_pc, halted, fetch_error);
      end
   endtask

   task automatic test_reset_midfetch();
      vectors++;
      if (out_valid !== 1'b1) begin errors++; $display("FAIL midrst_pre: ov=%b want 1", out_valid); end
      rst = 1; tick(); rst = 0;
      vectors++;
      if ({out_valid, halted, fetch_error, out_pc, out_instruction, program_counter} !== {3'b000, 96'd0}) begin
         errors++; $display("FAIL midrst: ov=%b h=%b err=%b opc=%h pc=%h want zeros", out_valid, halted, fetch_error, out_pc, program_counter);
      end
      repeat (3) tick();
      vectors++;
      if (out_valid !== 1'b0 || program_counter !== 32'd0) begin
         errors++; $display("FAIL midrst_idle: ov=%b pc=%h want 0 0", out_valid, program_counter);
      end
      start = 1; tick(); start = 0; tick();
      vectors++;
      if (out_valid !== 1'b1 || out_pc !== 32'd0) begin
         errors++; $display("FAIL midrst_restart: ov=%b opc=%h want 1 0", out_valid, out_pc);
      end
   endtask

   task automatic test_redirect_in_halted();
      out_ready = 1;
      go();
      repeat (8) tick();
      vectors++;
      if (halted !== 1'b1 || out_valid !== 1'b1 || out_pc !== 32'd7) begin
         errors++; $display("FAIL halt_pre: h=%b ov=%b opc=%h want 1 1 7", halted, out_valid, out_pc);
      end
      redirect_valid = 1; redirect_target = 32'd3;
      tick();
      redirect_valid = 0;
      vectors++;
      if (out_valid !== 1'b0 || halted !== 1'b0 || program_counter !== 32'd3) begin
         errors++; $display("FAIL halt_redirect: ov=%b h=%b pc=%h want 0 0 3", out_valid, halted, program_counter);
      end
      tick();
      vectors++;
      if (out_valid !== 1'b1 || out_pc !== 32'd3 || out_instruction !== mem[3]) begin
         errors++; $display("FAIL halt_resume: ov=%b opc=%h want 1 3", out_valid, out_pc);
      end
   endtask

   task automatic test_random();
      for (int c = 0; c < 800; c++) begin
         rst             = ($urandom_range(120) == 0);
         start           = ($urandom_range(5) == 0);
         redirect_valid  = ($urandom_range(11) == 0);
         redirect_target = ($urandom_range(15) == 0) ? 32'hFFFF_FFFF : 32'($urandom_range(11));
         out_ready       = ($urandom_range(3) != 0);
         tick();
         vectors++;
         if ({out_valid, halted, fetch_error, out_pc, out_instruction, program_counter} !==
             {m_ov, m_stopped, m_err, m_opc, m_oi, m_pc}) begin
            errors++;
            $display("FAIL random_c%0d: ov=%b h=%b err=%b opc=%h oi=%h pc=%h want %b %b %b %h %h %h",
                     c, out_valid, halted, fetch_error, out_pc, out_instruction, program_counter,
                     m_ov, m_stopped, m_err, m_opc, m_oi, m_pc);
         end
      end
      rst = 0; start = 0; redirect_valid = 0;
   endtask

   initial begin
      for (int i = 0; i < N; i++) mem[i] = $urandom;
      rst = 1; start = 0; redirect_valid = 0; redirect_target = 0; out_ready = 1;
      m_pc = 0; m_oi = 0; m_opc = 0; m_ov = 0; m_running = 0; m_stopped = 0; m_err = 0;
      test_reset();
      test_sequential();
      test_stall();
      test_redirect();
      test_bad_target();
      test_reset_midfetch();
      test_redirect_in_halted();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
